// File: rtl/traffic_pkg.sv
// traffic_pkg
//   Shared definitions for the traffic_control request front end:
//   light codes driven by traffic_control, the per-lane request FSM state
//   encoding, lane index constants and a light-code legality helper.
package traffic_pkg;

  // One-hot light codes as produced by traffic_control
  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;

  // Lane positions within det[] and starve[]
  localparam int LANE_N = 0;
  localparam int LANE_S = 1;
  localparam int LANE_E = 2;
  localparam int LANE_W = 3;

  typedef enum logic [1:0] {
    LANE_IDLE   = 2'd0,
    LANE_ARMED  = 2'd1,
    LANE_REQ    = 2'd2,
    LANE_SERVED = 2'd3
  } lane_state_t;

  // Anything other than the three one-hot codes is a fault on the light bus
  function automatic logic is_legal_light(input logic [2:0] code);
    return (code == LIGHT_RED) || (code == LIGHT_YEL) || (code == LIGHT_GRN);
  endfunction

endpackage

// File: rtl/traffic_lane_req.sv
// traffic_lane_req
//   One lane of the request generator: debounces the detector, latches a
//   request until the lane has been given green, ages the pending request
//   and flags starvation.
// Ports
//   clk     in   system clock, rising edge
//   rst_a   in   asynchronous reset, active-low
//   det     in   detector (already synchronous to clk)
//   green   in   this lane's light is exactly GRN
//   req     out  request pending (state is REQ)
//   starve  out  pending request has waited >= MAX_WAIT cycles
module traffic_lane_req
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int AGE_W           = 8,
  parameter int MAX_WAIT        = 200
) (
  input  logic clk,
  input  logic rst_a,
  input  logic det,
  input  logic green,
  output logic req,
  output logic starve
);

  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [AGE_W-1:0] AGE_MAX  = {AGE_W{1'b1}};
  localparam logic [AGE_W-1:0] AGE_STARVE = AGE_W'(MAX_WAIT);

  lane_state_t      state, state_nxt;
  logic [DEB_W-1:0] deb, deb_nxt;
  logic [AGE_W-1:0] age, age_nxt;

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      state <= LANE_IDLE;
      deb   <= '0;
      age   <= '0;
    end else begin
      state <= state_nxt;
      deb   <= deb_nxt;
      age   <= age_nxt;
    end
  end

  // The sample that arms the lane already counts as the first debounce
  // sample, so ARMED completes on the sample where deb == DEBOUNCE_CYCLES-1.
  // Green is ignored until a request is actually latched.
  always_comb begin
    state_nxt = state;
    deb_nxt   = deb;
    age_nxt   = age;
    case (state)
      LANE_IDLE: begin
        deb_nxt = '0;
        age_nxt = '0;
        if (det) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_nxt = LANE_REQ;
          end else begin
            state_nxt = LANE_ARMED;
            deb_nxt   = DEB_W'(1);
          end
        end
      end
      LANE_ARMED: begin
        if (!det) begin
          state_nxt = LANE_IDLE;
          deb_nxt   = '0;
        end else if (deb >= DEB_LAST) begin
          state_nxt = LANE_REQ;
          deb_nxt   = '0;
          age_nxt   = '0;
        end else begin
          deb_nxt = deb + DEB_W'(1);
        end
      end
      LANE_REQ: begin
        if (green) begin
          state_nxt = LANE_SERVED;
          age_nxt   = '0;
        end else if (age != AGE_MAX) begin
          age_nxt = age + AGE_W'(1);
        end
      end
      LANE_SERVED: begin
        age_nxt = '0;
        if (!green) begin
          state_nxt = LANE_IDLE;
        end
      end
      default: begin
        state_nxt = LANE_IDLE;
        deb_nxt   = '0;
        age_nxt   = '0;
      end
    endcase
  end

  // Both outputs decode only registered state, so there is no input-to-output path
  assign req    = (state == LANE_REQ);
  assign starve = (state == LANE_REQ) && (age >= AGE_STARVE);

endmodule

// File: rtl/traffic_request_gen.sv
// traffic_request_gen
//   Vehicle-detector front end for traffic_control. Turns raw loop detectors
//   into latched per-direction demands x1..x4 and retires each demand once
//   traffic_control has shown that direction green.
// Configuration macro
//   TRAFFIC_REQ_SYNC_EN  when defined, det passes through 2-flop synchronizers
//                        (adds 2 cycles det->x latency); otherwise det must
//                        already be synchronous to clk.
// Ports
//   clk         in   system clock, rising edge
//   rst_a       in   asynchronous reset, active-low
//   det[3:0]    in   raw detectors, bit0=N, bit1=S, bit2=E, bit3=W
//   n/s/e/w_lights in  light codes from traffic_control
//   x1..x4      out  north/south/east/west demand
//   starve[3:0] out  per-lane starvation flag
//   lights_err  out  sticky: a light input carried an illegal code
module traffic_request_gen
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int AGE_W           = 8,
  parameter int MAX_WAIT        = 200
) (
  input  logic       clk,
  input  logic       rst_a,
  input  logic [3:0] det,
  input  logic [2:0] n_lights,
  input  logic [2:0] s_lights,
  input  logic [2:0] e_lights,
  input  logic [2:0] w_lights,
  output logic       x1,
  output logic       x2,
  output logic       x3,
  output logic       x4,
  output logic [3:0] starve,
  output logic       lights_err
);

  logic [3:0]      det_q;
  logic [3:0][2:0] lights;
  logic [3:0]      green;
  logic [3:0]      bad_code;
  logic [3:0]      req;

`ifdef TRAFFIC_REQ_SYNC_EN
  logic [3:0] det_s1, det_s2;

  // Two-stage synchronizer for the asynchronous pad-level detectors
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      det_s1 <= '0;
      det_s2 <= '0;
    end else begin
      det_s1 <= det;
      det_s2 <= det_s1;
    end
  end

  assign det_q = det_s2;
`else
  assign det_q = det;
`endif

  assign lights[LANE_N] = n_lights;
  assign lights[LANE_S] = s_lights;
  assign lights[LANE_E] = e_lights;
  assign lights[LANE_W] = w_lights;

  always_comb begin
    green    = '0;
    bad_code = '0;
    for (int i = 0; i < 4; i++) begin
      green[i]    = (lights[i] == LIGHT_GRN);
      bad_code[i] = !is_legal_light(lights[i]);
    end
  end

  // Once any illegal light code is seen the flag holds until reset
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      lights_err <= 1'b0;
    end else if (|bad_code) begin
      lights_err <= 1'b1;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_lane
    traffic_lane_req #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .AGE_W          (AGE_W),
      .MAX_WAIT       (MAX_WAIT)
    ) u_lane (
      .clk   (clk),
      .rst_a (rst_a),
      .det   (det_q[g]),
      .green (green[g]),
      .req   (req[g]),
      .starve(starve[g])
    );
  end

  assign x1 = req[LANE_N];
  assign x2 = req[LANE_S];
  assign x3 = req[LANE_E];
  assign x4 = req[LANE_W];

endmodule

// File: tb/tb_traffic_request_gen.sv
// tb_traffic_request_gen
//   Directed bench for traffic_request_gen with default parameters
//   (DEBOUNCE_CYCLES=4, MAX_WAIT=200). Expected output vectors
//   {lights_err, starve, x4..x1} are queued as each cycle's stimulus is
//   driven and compared after the following rising edge.
module tb_traffic_request_gen;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] GRN = 3'b001;
  localparam int DEB = 4;
  localparam int MAXW = 200;
`ifdef TRAFFIC_REQ_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  typedef struct {
    string      tag;
    logic [8:0] vec;
  } exp_t;

  logic       clk;
  logic       rst_a;
  logic [3:0] det;
  logic [2:0] n_lights, s_lights, e_lights, w_lights;
  logic       x1, x2, x3, x4;
  logic [3:0] starve;
  logic       lights_err;

  logic [3:0] ex_x;
  logic [3:0] ex_starve;
  logic       ex_err;
  exp_t       sb[$];
  int         assertions = 0;
  int         failures   = 0;

  traffic_request_gen dut (
    .clk       (clk),
    .rst_a     (rst_a),
    .det       (det),
    .n_lights  (n_lights),
    .s_lights  (s_lights),
    .e_lights  (e_lights),
    .w_lights  (w_lights),
    .x1        (x1),
    .x2        (x2),
    .x3        (x3),
    .x4        (x4),
    .starve    (starve),
    .lights_err(lights_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_expected(input string tag);
    exp_t e;
    e.tag = tag;
    e.vec = {ex_err, ex_starve, ex_x};
    sb.push_back(e);
  endtask

  task automatic check_output();
    exp_t       e;
    logic [8:0] obs;
    e   = sb.pop_front();
    obs = {lights_err, starve, x4, x3, x2, x1};
    assertions++;
    assert (obs === e.vec)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", e.tag, obs, e.vec);
    end
  endtask

  // Inputs are already set by the caller; the expectation holds after the next edge
  task automatic apply_stimulus(input string tag);
    push_expected(tag);
    @(posedge clk);
    #1;
    check_output();
  endtask

  initial begin
    rst_a = 1'b0;
    det = 4'b0000;
    n_lights = RED; s_lights = RED; e_lights = RED; w_lights = RED;
    ex_x = 4'b0000; ex_starve = 4'b0000; ex_err = 1'b0;

    #12;
    push_expected("reset_state");
    check_output();
    rst_a = 1'b1;
    @(posedge clk); #1;
    apply_stimulus("idle_after_reset");

    // Scenario 2: north debounce completes after the 4th sample
    det[0] = 1'b1;
    for (int i = 0; i < DEB - 1 + SL; i++) apply_stimulus("x1_debouncing");
    ex_x[0] = 1'b1;
    apply_stimulus("x1_rise");
    det[0] = 1'b0;
    apply_stimulus("x1_latched");
    n_lights = GRN;
    ex_x[0] = 1'b0;
    apply_stimulus("x1_retired");
    n_lights = RED;
    apply_stimulus("x1_idle_red");

    // Short pulse of 3 samples never raises a request
    det[0] = 1'b1;
    for (int i = 0; i < 3; i++) apply_stimulus("x1_short_pulse");
    det[0] = 1'b0;
    for (int i = 0; i < 3 + SL; i++) apply_stimulus("x1_short_after");

    // Scenario 3: south served while detector stays high, re-requests after red
    det[1] = 1'b1;
    for (int i = 0; i < DEB - 1 + SL; i++) apply_stimulus("x2_debouncing");
    ex_x[1] = 1'b1;
    apply_stimulus("x2_rise");
    s_lights = GRN;
    ex_x[1] = 1'b0;
    for (int i = 0; i < 5; i++) apply_stimulus("x2_green_hold");
    s_lights = RED;
    for (int i = 0; i < DEB; i++) apply_stimulus("x2_rearm");
    ex_x[1] = 1'b1;
    apply_stimulus("x2_rerequest");
    det[1] = 1'b0;
    s_lights = GRN;
    ex_x[1] = 1'b0;
    apply_stimulus("x2_retire");
    s_lights = RED;
    apply_stimulus("x2_idle");

    // Scenario 4: east starves after 200 cycles of red
    det[2] = 1'b1;
    for (int i = 0; i < DEB - 1 + SL; i++) apply_stimulus("x3_debouncing");
    ex_x[2] = 1'b1;
    apply_stimulus("x3_rise");
    det[2] = 1'b0;
    for (int i = 0; i < MAXW - 1; i++) apply_stimulus("starve_low");
    ex_starve[2] = 1'b1;
    apply_stimulus("starve_rise");
    apply_stimulus("starve_hold");
    e_lights = GRN;
    ex_x[2] = 1'b0;
    ex_starve[2] = 1'b0;
    apply_stimulus("starve_cleared");
    e_lights = RED;
    apply_stimulus("x3_idle");

    // Scenario 5: illegal north code flags error but does not retire x1
    det[0] = 1'b1;
    for (int i = 0; i < DEB - 1 + SL; i++) apply_stimulus("x1b_debouncing");
    ex_x[0] = 1'b1;
    apply_stimulus("x1b_rise");
    det[0] = 1'b0;
    n_lights = 3'b011;
    ex_err = 1'b1;
    apply_stimulus("lights_err_set");
    n_lights = RED;
    apply_stimulus("lights_err_sticky");
    apply_stimulus("lights_err_sticky2");

    // Scenario 1: all lanes pending, then asynchronous reset clears everything
    det = 4'b1111;
    for (int i = 0; i < DEB - 1 + SL; i++) apply_stimulus("all_debouncing");
    ex_x = 4'b1111;
    apply_stimulus("all_requesting");
    det = 4'b0000;
    apply_stimulus("all_latched");
    #3;
    rst_a = 1'b0;
    #1;
    ex_x = 4'b0000; ex_starve = 4'b0000; ex_err = 1'b0;
    push_expected("async_reset");
    check_output();
    @(posedge clk); #1;
    rst_a = 1'b1;
    apply_stimulus("post_reset_idle");
    apply_stimulus("post_reset_idle2");

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
